cr_huf_comp_tlv_ob_arb: RTL

Round-robin packet arbiter that lets several TLV producers inside the Huffman compressor share the single user-output write port (`usr_wr`/`usr_tlv`/`usr_afull`) of the compressor's TLV parser. Each requester presents a FIFO-style read interface. The arbiter grants one requester at a time and holds that grant for a whole TLV, from the word with `sot` through the word with `eot`. It forwards words through one register stage and throttles on the parser's almost-full flag.

---
 rtl/cr_huf_comp_tlv_ob_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cr_huf_comp_tlv_ob_arb.sv
// ---------------------------------------------------------------------------
// cr_huf_comp_tlv_ob_arb
//
// Round-robin packet arbiter that lets several TLV producers share the single
// user-output write port of the compressor's TLV parser. A grant is held for a
// whole TLV (sot .. eot); words pass through one output register stage and
// popping is throttled by the parser's almost-full flag.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_empty      per-requester FIFO empty
//   req_tlv        per-requester head-of-FIFO word
//   req_rd         per-requester pop (one-hot or zero)
//   usr_wr         write strobe to the parser user-output FIFO
//   usr_tlv        write data
//   usr_afull      parser user-output FIFO almost full (blocks pops)
//   usr_full       parser user-output FIFO full (monitored only)
//   arb_pkt_done   pulse coincident with the usr_wr of an eot word
//   arb_sot_err    sticky framing error, cleared only by reset
//   arb_grant      current or last grant index
// ---------------------------------------------------------------------------

package cr_huf_comp_tlv_ob_arb_pkg;

    typedef struct packed {
        logic        sot;
        logic        eot;
        logic [3:0]  tuser;
        logic [15:0] tdata;
    } tlvp_if_bus_t;

endpackage

module cr_huf_comp_tlv_ob_arb
    import cr_huf_comp_tlv_ob_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic         [N_REQ-1:0]     req_empty,
    input  tlvp_if_bus_t [N_REQ-1:0]     req_tlv,
    output logic         [N_REQ-1:0]     req_rd,
    output logic                         usr_wr,
    output tlvp_if_bus_t                 usr_tlv,
    input  logic                         usr_afull,
    input  logic                         usr_full,
    output logic                         arb_pkt_done,
    output logic                         arb_sot_err,
    output logic         [PTR_W-1:0]     arb_grant
);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               first_q, first_d;
    logic               usr_wr_q, usr_wr_d;
    tlvp_if_bus_t       usr_tlv_q, usr_tlv_d;
    logic               pkt_done_q, pkt_done_d;
    logic               sot_err_q, sot_err_d;

    logic               found;
    logic               pop;
    int unsigned        sum;
    logic [PTR_W-1:0]   idx;
    tlvp_if_bus_t       head;

    // Full is guaranteed unreachable by afull slack; kept on the port for
    // monitoring only.
    logic unused_usr_full;
    assign unused_usr_full = usr_full;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        first_d    = first_q;
        usr_wr_d   = 1'b0;
        usr_tlv_d  = usr_tlv_q;
        pkt_done_d = 1'b0;
        sot_err_d  = sot_err_q;
        req_rd     = '0;
        found      = 1'b0;
        pop        = 1'b0;
        sum        = 0;
        idx        = '0;
        head       = req_tlv[grant_q];

        unique case (state_q)
            StIdle: begin
                // Cyclic search starting at rr_ptr; first non-empty wins.
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    sum = 32'(rr_ptr_q) + i;
                    if (sum >= N_REQ) begin
                        sum = sum - N_REQ;
                    end
                    idx = PTR_W'(sum);
                    if (!found && !req_empty[idx]) begin
                        found   = 1'b1;
                        grant_d = idx;
                    end
                end
                if (found) begin
                    state_d = StBusy;
                    first_d = 1'b1;
                end
            end

            StBusy: begin
                // Grant is held even while the requester is empty mid-packet.
                pop             = !req_empty[grant_q] && !usr_afull;
                req_rd[grant_q] = pop;
                if (pop) begin
                    usr_wr_d   = 1'b1;
                    usr_tlv_d  = head;
                    pkt_done_d = head.eot;
                    first_d    = 1'b0;
                    if (first_q ? !head.sot : head.sot) begin
                        sot_err_d = 1'b1;
                    end
                    if (head.eot) begin
                        state_d = StIdle;
                        if (grant_q == PTR_W'(N_REQ - 1)) begin
                            rr_ptr_d = '0;
                        end else begin
                            rr_ptr_d = grant_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            first_q    <= 1'b0;
            usr_wr_q   <= 1'b0;
            usr_tlv_q  <= '0;
            pkt_done_q <= 1'b0;
            sot_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            first_q    <= first_d;
            usr_wr_q   <= usr_wr_d;
            usr_tlv_q  <= usr_tlv_d;
            pkt_done_q <= pkt_done_d;
            sot_err_q  <= sot_err_d;
        end
    end

    assign usr_wr       = usr_wr_q;
    assign usr_tlv      = usr_tlv_q;
    assign arb_pkt_done = pkt_done_q;
    assign arb_sot_err  = sot_err_q;
    assign arb_grant    = grant_q;

endmodule
